stream_batch_sorter: RTL



---
 rtl/stream_batch_sorter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/stream_batch_sorter.sv
// Streaming batch sorter: loads N words, sorts them with an odd-even
// transposition network (one pass per cycle), then drains them in order.
module stream_batch_sorter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              descend,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(N) + 1;
  localparam int unsigned IDX_W = $clog2(N);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_pass;
  logic              r_desc;
  logic [DATA_W-1:0] r_buf [N];
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_busy;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_idx_nxt;
  logic [CNT_W-1:0]  w_pass_nxt;
  logic              w_desc_nxt;
  logic [DATA_W-1:0] w_buf_nxt [N];
  logic              w_in_ready_nxt;
  logic              w_out_valid_nxt;
  logic [DATA_W-1:0] w_out_data_nxt;
  logic              w_out_last_nxt;
  logic              w_busy_nxt;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_swap;

  assign w_in_fire  = in_valid  && r_in_ready;
  assign w_out_fire = out_ready && r_out_valid;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

  // Next-state, datapath update and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pass_nxt  = r_pass;
    w_desc_nxt  = r_desc;
    w_buf_nxt   = r_buf;
    w_swap      = 1'b0;

    case (r_state)
      S_LOAD: begin
        if (w_in_fire) begin
          w_buf_nxt[r_idx[IDX_W-1:0]] = in_data;
          if (r_idx == '0) begin
            w_desc_nxt = descend;
          end
          if (r_idx == CNT_W'(N - 1)) begin
            w_state_nxt = S_SORT;
            w_idx_nxt   = '0;
            w_pass_nxt  = '0;
          end else begin
            w_idx_nxt = r_idx + CNT_W'(1);
          end
        end
      end

      S_SORT: begin
        // Even passes pair (0,1),(2,3)..; odd passes pair (1,2),(3,4)..
        for (int unsigned i = 0; i < N - 1; i++) begin
          if (1'(i) == r_pass[0]) begin
            w_swap = r_desc ? (r_buf[i] < r_buf[i+1]) : (r_buf[i] > r_buf[i+1]);
            if (w_swap) begin
              w_buf_nxt[i]   = r_buf[i+1];
              w_buf_nxt[i+1] = r_buf[i];
            end
          end
        end
        if (r_pass == CNT_W'(N - 1)) begin
          w_state_nxt = S_DRAIN;
          w_idx_nxt   = '0;
        end else begin
          w_pass_nxt = r_pass + CNT_W'(1);
        end
      end

      S_DRAIN: begin
        if (w_out_fire) begin
          if (r_idx == CNT_W'(N - 1)) begin
            w_state_nxt = S_LOAD;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + CNT_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_LOAD;
        w_idx_nxt   = '0;
        w_pass_nxt  = '0;
      end
    endcase

    w_in_ready_nxt  = (w_state_nxt == S_LOAD);
    w_out_valid_nxt = (w_state_nxt == S_DRAIN);
    w_busy_nxt      = (w_state_nxt != S_LOAD);
    w_out_last_nxt  = (w_state_nxt == S_DRAIN) && (w_idx_nxt == CNT_W'(N - 1));
    w_out_data_nxt  = (w_state_nxt == S_DRAIN) ? w_buf_nxt[w_idx_nxt[IDX_W-1:0]] : r_out_data;
  end

  // State, buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_idx       <= '0;
      r_pass      <= '0;
      r_desc      <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_pass      <= w_pass_nxt;
      r_desc      <= w_desc_nxt;
      r_buf       <= w_buf_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

endmodule
